// File: rtl/validacion_persistente.sv
// Persistence filter for a current-level field and a smoke flag, with reserved-bit checking and a stale-data flag.
// Optional smoke alarm latch: define VALIDACION_HUMO_LATCH_EN.

module validacion_campo #(
  parameter int W       = 3,
  parameter int PERSIST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         muestra,
  input  logic         borrar,
  input  logic [W-1:0] campo,
  output logic [W-1:0] valor,
  output logic [W-1:0] valor_next
);

  typedef enum logic [1:0] {IDLE, TRACK, STABLE} estado_t;

  localparam logic [7:0] PERSIST_C = 8'(PERSIST);

  estado_t      estado_reg, estado_next;
  logic [W-1:0] cand_reg, cand_next;
  logic [7:0]   cnt_reg, cnt_next;
  logic [W-1:0] valor_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_reg <= IDLE;
      cand_reg   <= '0;
      cnt_reg    <= '0;
      valor_reg  <= '0;
    end else begin
      estado_reg <= estado_next;
      cand_reg   <= cand_next;
      cnt_reg    <= cnt_next;
      valor_reg  <= valor_next;
    end
  end

  always_comb begin
    estado_next = estado_reg;
    cand_next   = cand_reg;
    cnt_next    = cnt_reg;
    valor_next  = valor_reg;
    if (borrar) begin
      cnt_next    = '0;
      estado_next = IDLE;
    end else if (muestra) begin
      if (campo != cand_reg) begin
        cand_next = campo;
        cnt_next  = 8'd1;
      end else if (estado_reg != STABLE) begin
        cnt_next = cnt_reg + 8'd1;
      end
      estado_next = (cnt_next == PERSIST_C) ? STABLE : TRACK;
      // Reload only on the edge that reaches PERSIST, never while already saturated.
      if ((cnt_next == PERSIST_C) && ((estado_reg != STABLE) || (campo != cand_reg)))
        valor_next = cand_next;
    end
  end

  assign valor = valor_reg;

endmodule

module validacion_persistente #(
  parameter int N       = 8,
  parameter int R       = 3,
  parameter int PERSIST = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         data_valid,
  input  logic         ack_humo,
  output logic [R-1:0] senal_corriente,
  output logic         senal_humo,
  output logic         cambio,
  output logic         error_dato,
  output logic         sin_datos
);

  localparam int            IW        = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);

  logic          reservado_nz;
  logic          muestra, borrar;
  logic [R-1:0]  corr_val, corr_next;
  logic          humo_val, humo_val_next, humo_next;
  logic          cambio_reg, error_reg;
  logic [IW-1:0] idle_reg;

  generate
    if (N > R + 1) begin : g_rsv
      assign reservado_nz = |data_in[N-1:R+1];
    end else begin : g_no_rsv
      assign reservado_nz = 1'b0;
    end
  endgenerate

  assign muestra = data_valid & ~reservado_nz;
  assign borrar  = data_valid & reservado_nz;

  validacion_campo #(.W(R), .PERSIST(PERSIST)) u_corriente (
    .clk        (clk),
    .reset      (reset),
    .muestra    (muestra),
    .borrar     (borrar),
    .campo      (data_in[R-1:0]),
    .valor      (corr_val),
    .valor_next (corr_next)
  );

  validacion_campo #(.W(1), .PERSIST(PERSIST)) u_humo (
    .clk        (clk),
    .reset      (reset),
    .muestra    (muestra),
    .borrar     (borrar),
    .campo      (data_in[R]),
    .valor      (humo_val),
    .valor_next (humo_val_next)
  );

`ifdef VALIDACION_HUMO_LATCH_EN
  logic humo_reg;

  // Once raised, the alarm only drops on an acknowledge while the filtered smoke flag is clear.
  assign humo_next = humo_val_next | (humo_reg & ~ack_humo);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) humo_reg <= 1'b0;
    else        humo_reg <= humo_next;
  end

  assign senal_humo = humo_reg;
`else
  logic unused_ack;
  assign unused_ack = ack_humo;
  assign humo_next  = humo_val_next;
  assign senal_humo = humo_val;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cambio_reg <= 1'b0;
      error_reg  <= 1'b0;
      idle_reg   <= '0;
    end else begin
      cambio_reg <= (corr_next != corr_val) | (humo_next != senal_humo);
      error_reg  <= borrar;
      if (data_valid)
        idle_reg <= '0;
      else if (idle_reg != TIMEOUT_C)
        idle_reg <= idle_reg + IW'(1);
    end
  end

  assign senal_corriente = corr_val;
  assign cambio          = cambio_reg;
  assign error_dato      = error_reg;
  assign sin_datos       = (idle_reg == TIMEOUT_C);

endmodule

// File: tb/tb_validacion_persistente.sv
// Bench for validacion_persistente: directed vector table, timeout/reset sequences, then randomized traffic vs a run-length model.
module tb_validacion_persistente;

  localparam int N       = 8;
  localparam int R       = 3;
  localparam int PERSIST = 4;
  localparam int TIMEOUT = 1000;
`ifdef VALIDACION_HUMO_LATCH_EN
  localparam int LATCH = 1;
`else
  localparam int LATCH = 0;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] data_in;
  logic         data_valid;
  logic         ack_humo;
  logic [R-1:0] senal_corriente;
  logic         senal_humo;
  logic         cambio;
  logic         error_dato;
  logic         sin_datos;

  validacion_persistente #(.N(N), .R(R), .PERSIST(PERSIST), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .ack_humo        (ack_humo),
    .senal_corriente (senal_corriente),
    .senal_humo      (senal_humo),
    .cambio          (cambio),
    .error_dato      (error_dato),
    .sin_datos       (sin_datos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: keeps the accepted history of each field since the last clear;
  // an output reloads when the trailing run of identical values is exactly PERSIST long.
  int hist_c[$];
  int hist_h[$];
  int m_corr, m_humo_val, m_humo, m_cambio, m_err, m_idle;

  function automatic int run_len(input int q[$]);
    int n = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i] == q[q.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_reset();
    hist_c.delete();
    hist_h.delete();
    m_corr = 0; m_humo_val = 0; m_humo = 0; m_cambio = 0; m_err = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit ack);
    int nc, nhv, nh;
    nc  = m_corr;
    nhv = m_humo_val;
    m_err = (v && ((d >> (R + 1)) != 0)) ? 1 : 0;
    if (v) begin
      if (m_err != 0) begin
        hist_c.delete();
        hist_h.delete();
      end else begin
        hist_c.push_back(d % (1 << R));
        hist_h.push_back((d >> R) % 2);
        if (hist_c.size() > PERSIST + 1) void'(hist_c.pop_front());
        if (hist_h.size() > PERSIST + 1) void'(hist_h.pop_front());
        if (run_len(hist_c) == PERSIST) nc  = hist_c[hist_c.size() - 1];
        if (run_len(hist_h) == PERSIST) nhv = hist_h[hist_h.size() - 1];
      end
    end
    if (LATCH != 0) nh = (nhv != 0 || (m_humo != 0 && !ack)) ? 1 : 0;
    else            nh = nhv;
    m_cambio   = (nc != m_corr || nh != m_humo) ? 1 : 0;
    m_corr     = nc;
    m_humo_val = nhv;
    m_humo     = nh;
    if (v)                      m_idle = 0;
    else if (m_idle < TIMEOUT)  m_idle = m_idle + 1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input int d, input bit ack);
    data_valid = v;
    data_in    = N'(d);
    ack_humo   = ack;
    @(posedge clk);
    model_step(v, d, ack);
    #1;
    data_valid = 1'b0;
    ack_humo   = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_corriente"}, int'(senal_corriente), m_corr);
    check({tag, "_humo"},      int'(senal_humo),      m_humo);
    check({tag, "_cambio"},    int'(cambio),          m_cambio);
    check({tag, "_error"},     int'(error_dato),      m_err);
    check({tag, "_sin_datos"}, int'(sin_datos),       (m_idle == TIMEOUT) ? 1 : 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_corriente"}, int'(senal_corriente), 0);
    check({tag, "_humo"},      int'(senal_humo),      0);
    check({tag, "_cambio"},    int'(cambio),          0);
    check({tag, "_error"},     int'(error_dato),      0);
    check({tag, "_sin_datos"}, int'(sin_datos),       0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    data_valid = 1'b0;
    ack_humo   = 1'b0;
    reset      = 1'b0;
    #2;
    check_all_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    bit v;
    int d;
    bit ack;
    int corr;
    int humo;
    int camb;
    int err;
  } vec_t;

  vec_t tabla[19];

  initial begin
    int hb, cf, rsv, d;
    bit v, ack;

    tabla[0]  = '{1'b1, 'h05, 1'b0, 0, 0, 0, 0};
    tabla[1]  = '{1'b1, 'h05, 1'b0, 0, 0, 0, 0};
    tabla[2]  = '{1'b1, 'h03, 1'b0, 0, 0, 0, 0};
    tabla[3]  = '{1'b1, 'h05, 1'b0, 0, 0, 0, 0};
    tabla[4]  = '{1'b1, 'h05, 1'b0, 0, 0, 0, 0};
    tabla[5]  = '{1'b1, 'h05, 1'b0, 0, 0, 0, 0};
    tabla[6]  = '{1'b1, 'h05, 1'b0, 5, 0, 1, 0};
    tabla[7]  = '{1'b0, 'h00, 1'b0, 5, 0, 0, 0};
    tabla[8]  = '{1'b1, 'h05, 1'b0, 5, 0, 0, 0};
    tabla[9]  = '{1'b1, 'h45, 1'b0, 5, 0, 0, 1};
    tabla[10] = '{1'b1, 'h0D, 1'b0, 5, 0, 0, 0};
    tabla[11] = '{1'b1, 'h0D, 1'b0, 5, 0, 0, 0};
    tabla[12] = '{1'b1, 'h0D, 1'b0, 5, 0, 0, 0};
    tabla[13] = '{1'b1, 'h0D, 1'b0, 5, 1, 1, 0};
    tabla[14] = '{1'b1, 'h05, 1'b0, 5, 1, 0, 0};
    tabla[15] = '{1'b1, 'h05, 1'b0, 5, 1, 0, 0};
    tabla[16] = '{1'b1, 'h05, 1'b0, 5, 1, 0, 0};
    tabla[17] = '{1'b1, 'h05, 1'b0, 5, LATCH, 1 - LATCH, 0};
    tabla[18] = '{1'b0, 'h00, 1'b1, 5, 0, LATCH, 0};

    reset      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    ack_humo   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(tabla[i].v, tabla[i].d, tabla[i].ack);
      check($sformatf("vec%0d_corriente", i), int'(senal_corriente), tabla[i].corr);
      check($sformatf("vec%0d_humo", i),      int'(senal_humo),      tabla[i].humo);
      check($sformatf("vec%0d_cambio", i),    int'(cambio),          tabla[i].camb);
      check($sformatf("vec%0d_error", i),     int'(error_dato),      tabla[i].err);
      check($sformatf("vec%0d_sin_datos", i), int'(sin_datos),       0);
      $display("[TB] vec %0d v=%0d d=%02h ack=%0d -> corr=%0d humo=%0d cambio=%0d err=%0d",
               i, tabla[i].v, tabla[i].d, tabla[i].ack, senal_corriente, senal_humo, cambio, error_dato);
    end

    // Stale flag: exactly TIMEOUT idle edges, then one strobe clears it.
    do_reset("rst_timeout");
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(1'b0, 0, 1'b0);
      if (i == TIMEOUT - 1) check("sin_datos_before", int'(sin_datos), 0);
      if (i == TIMEOUT)     check("sin_datos_at_timeout", int'(sin_datos), 1);
    end
    $display("[TB] timeout reached: sin_datos=%0d", sin_datos);
    step(1'b1, 'h05, 1'b0);
    check("sin_datos_clear", int'(sin_datos), 0);
    check("timeout_corriente_hold", int'(senal_corriente), 0);
    check("timeout_cambio", int'(cambio), 0);
    $display("[TB] strobe after timeout: sin_datos=%0d corr=%0d", sin_datos, senal_corriente);

    // Mid-sequence reset discards partial persistence.
    do_reset("rst_pre");
    for (int i = 0; i < 4; i++) step(1'b1, 'h06, 1'b0);
    check("pre_corriente", int'(senal_corriente), 6);
    for (int i = 0; i < 3; i++) step(1'b1, 'h05, 1'b0);
    do_reset("rst_mid");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 'h05, 1'b0);
      check($sformatf("post_rst_%0d_corriente", i), int'(senal_corriente), 0);
    end
    step(1'b1, 'h05, 1'b0);
    check("post_rst_4_corriente", int'(senal_corriente), 5);
    check("post_rst_4_cambio", int'(cambio), 1);
    $display("[TB] reset sequence done: corr=%0d cambio=%0d", senal_corriente, cambio);

    // Randomized traffic with narrow value sets so persistence runs occur often.
    do_reset("rst_rand");
    hb = 0;
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      ack = ($urandom_range(0, 3) == 0);
      cf  = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) hb = 1 - hb;
      rsv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : 0;
      d   = (rsv << (R + 1)) | (hb << R) | cf;
      step(v, d, ack);
      compare_model($sformatf("rand%0d", i));
      if (i % 250 == 0)
        $display("[TB] rand %0d v=%0d d=%02h ack=%0d -> corr=%0d humo=%0d cambio=%0d err=%0d",
                 i, v, d, ack, senal_corriente, senal_humo, cambio, error_dato);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/validacion_persistente.md
VALIDACION_PERSISTENTE -- requirements
Module: validacion_persistente

Interface
REQ-001 Parameter N, default 8: data_in width; SHALL be >= R+1.
REQ-002 Parameter R, default 3: current-level field width.
REQ-003 Parameter PERSIST, default 4: consecutive identical valid samples needed to update an output; range 1..255.
REQ-004 Parameter TIMEOUT, default 1000: clock cycles without a strobe before stale flag; range 2..2^20.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 data_in  input  N  raw sample; [R-1:0] current level, [R] smoke flag, [N-1:R+1] reserved.
REQ-008 data_valid  input  1  sample strobe; data_in sampled on each clk edge where high.
REQ-009 ack_humo  input  1  smoke-alarm acknowledge; used only when latch feature compiled in.
REQ-010 senal_corriente  output  R  validated current level, registered.
REQ-011 senal_humo  output  1  validated smoke flag, registered.
REQ-012 cambio  output  1  one-cycle pulse on any change of senal_corriente or senal_humo.
REQ-013 error_dato  output  1  one-cycle pulse when an accepted sample has nonzero reserved bits.
REQ-014 sin_datos  output  1  stale flag; level.

Function
REQ-015 Sample invalid iff data_valid=1 and data_in[N-1:R+1]!=0; invalid sample SHALL pulse error_dato next cycle, clear both persistence counts to 0, leave outputs unchanged.
REQ-016 Current and smoke fields SHALL each have independent candidate register and saturating count (0..PERSIST).
REQ-017 Valid sample, field==candidate: count <= min(count+1, PERSIST); field!=candidate: candidate <= field, count <= 1.
REQ-018 Output SHALL load candidate on the edge where its count becomes PERSIST (incl. mismatch case when PERSIST=1); visible the following cycle; count already saturated SHALL NOT reload.
REQ-019 cambio SHALL pulse one cycle on the edge after which any output value differs; reload with equal value SHALL NOT pulse; simultaneous change of both fields SHALL give a single pulse.
REQ-020 No strobe: candidates, counts, outputs hold.
REQ-021 Idle counter SHALL clear on every strobe (valid or invalid) and otherwise increment, saturating at TIMEOUT.
REQ-022 sin_datos SHALL be 1 while idle counter == TIMEOUT; clears on the edge of next strobe; outputs unchanged when it asserts.
REQ-023 States per field: IDLE (count 0), TRACK (0<count<PERSIST), STABLE (count==PERSIST); transitions exactly per REQ-015/017.

Reset
REQ-024 reset low SHALL immediately force: senal_corriente=0, senal_humo=0, cambio=0, error_dato=0, sin_datos=0, candidates=0, counts=0, idle counter=0, alarm latch=0.
REQ-025 Reset asserted mid-sequence SHALL discard partial persistence; after release a full PERSIST run is required.
REQ-026 First edge after reset release SHALL process data_valid normally.

Configuration
REQ-027 Macro VALIDACION_HUMO_LATCH_EN defined: senal_humo, once set to 1, SHALL stay 1 until a clock edge with ack_humo=1 and validated smoke field 0; that clear pulses cambio.
REQ-028 Macro undefined: senal_humo follows REQ-018 only; ack_humo ignored; no latch logic.

Verification
REQ-029 Defaults; four strobes data_in=8'h05 -> senal_corriente=3'd5, senal_humo=0, one cambio pulse one cycle after 4th strobe; three strobes only -> outputs stay 0.
REQ-030 Strobes 8'h05,8'h05,8'h03,8'h05x4 -> no update until 4th consecutive 8'h05; cambio exactly once.
REQ-031 Established 8'h05; strobes 8'h05,8'h45,8'h0D x4 -> error_dato pulse after 8'h45; senal_humo=1, corriente 5 after 4th 8'h0D.
REQ-032 No strobe 1000 cycles -> sin_datos=1 at cycle 1000; one strobe -> sin_datos=0 next cycle, outputs unchanged.
REQ-033 Macro defined; smoke set, then 4x 8'h05 -> senal_humo stays 1; ack_humo=1 -> senal_humo=0, cambio pulse; macro undefined -> clears after 4th sample.
REQ-034 Reset low after 3 of 4 matching strobes -> all outputs 0 immediately; after release 4 further strobes required.
